// File: rtl/can_bit_destuffer_if.sv
// Bit-level receive bus between the CAN line front end and the frame-field tracker.
// The master drives the line and the stuffing window; the slave returns destuffed bits and status.
interface can_bit_destuffer_if;
   logic i_Rx;
   logic i_Stuff_Enable;
   logic o_Data;
   logic o_Data_Valid;
   logic o_Stuff_Error;
   logic o_Bus_Idle;

   modport master (
      output i_Rx,
      output i_Stuff_Enable,
      input  o_Data,
      input  o_Data_Valid,
      input  o_Stuff_Error,
      input  o_Bus_Idle
   );

   modport slave (
      input  i_Rx,
      input  i_Stuff_Enable,
      output o_Data,
      output o_Data_Valid,
      output o_Stuff_Error,
      output o_Bus_Idle
   );
endinterface

// File: rtl/can_bit_destuffer.sv
// CAN receive front end: syncs RX, hard-syncs on SOF, samples one bit per bit time and strips stuff bits.
// Strobe lands SAMPLE_POINT+1 clocks after hard sync, then every CLKS_PER_BIT; no backpressure, strobe only.
module can_bit_destuffer #(
   parameter int CLKS_PER_BIT = 10,
   parameter int SAMPLE_POINT = 7,
   parameter int IDLE_BITS    = 11
) (
   input  logic               i_Clock,
   input  logic               i_Reset,
   can_bit_destuffer_if.slave bus
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int RW = $clog2(IDLE_BITS + 1);
   localparam logic [CW-1:0] CNT_LAST   = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_SAMPLE = CW'(SAMPLE_POINT);
   localparam logic [RW-1:0] REC_IDLE   = RW'(IDLE_BITS);

   typedef enum logic [1:0] {
      WAIT_IDLE = 2'd0,
      IDLE      = 2'd1,
      RECEIVE   = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            rx_meta, rx_sync, rx_prev;
   logic [CW-1:0]   clock_count, clock_count_d, cnt_eff;
   logic [RW-1:0]   rec_count, rec_count_d;
   logic [2:0]      same_count, same_count_d;
   logic            last_bit, last_bit_d;
   logic            data_q, data_d;
   logic            data_vld_q, data_vld_d;
   logic            stuff_err_q, stuff_err_d;
   logic            bus_idle_q, bus_idle_d;
   logic            fall, hard_sync, sample, bit_b;

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= bus.i_Rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state_q     <= WAIT_IDLE;
         clock_count <= '0;
         rec_count   <= '0;
         same_count  <= '0;
         last_bit    <= 1'b1;
         data_q      <= 1'b1;
         data_vld_q  <= 1'b0;
         stuff_err_q <= 1'b0;
         bus_idle_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         clock_count <= clock_count_d;
         rec_count   <= rec_count_d;
         same_count  <= same_count_d;
         last_bit    <= last_bit_d;
         data_q      <= data_d;
         data_vld_q  <= data_vld_d;
         stuff_err_q <= stuff_err_d;
         bus_idle_q  <= bus_idle_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      rec_count_d  = rec_count;
      same_count_d = same_count;
      last_bit_d   = last_bit;
      data_d       = data_q;
      data_vld_d   = 1'b0;
      stuff_err_d  = stuff_err_q;
      bus_idle_d   = bus_idle_q;

      fall      = rx_prev & ~rx_sync;
      hard_sync = (state_q == IDLE) && fall;
      bit_b     = rx_sync;

      // Hard sync makes this cycle count zero, so the sample lands SAMPLE_POINT clocks later.
      cnt_eff       = hard_sync ? '0 : clock_count;
      sample        = (cnt_eff == CNT_SAMPLE);
      clock_count_d = (cnt_eff == CNT_LAST) ? '0 : cnt_eff + 1'b1;

      if (sample) begin
         if (!bit_b)
            rec_count_d = '0;
         else if (rec_count != REC_IDLE)
            rec_count_d = rec_count + 1'b1;
      end

      case (state_q)
         WAIT_IDLE: begin
            if (sample && rec_count_d == REC_IDLE) begin
               bus_idle_d = 1'b1;
               state_d    = IDLE;
            end
         end
         IDLE: begin
            if (fall) begin
               stuff_err_d  = 1'b0;
               bus_idle_d   = 1'b0;
               same_count_d = '0;
               state_d      = RECEIVE;
            end
         end
         RECEIVE: begin
            if (sample) begin
               if (bus.i_Stuff_Enable && same_count == 3'd5) begin
                  if (bit_b != last_bit) begin
                     same_count_d = 3'd1;
                     last_bit_d   = bit_b;
                  end else begin
                     stuff_err_d = 1'b1;
                     bus_idle_d  = 1'b0;
                     rec_count_d = '0;
                     state_d     = WAIT_IDLE;
                  end
               end else begin
                  data_d     = bit_b;
                  data_vld_d = 1'b1;
                  if (bus.i_Stuff_Enable) begin
                     same_count_d = (bit_b == last_bit) ? same_count + 3'd1 : 3'd1;
                     last_bit_d   = bit_b;
                  end else begin
                     same_count_d = '0;
                  end
                  if (rec_count_d == REC_IDLE) begin
                     bus_idle_d = 1'b1;
                     state_d    = IDLE;
                  end
               end
            end
         end
         default: state_d = WAIT_IDLE;
      endcase
   end

   assign bus.o_Data        = data_q;
   assign bus.o_Data_Valid  = data_vld_q;
   assign bus.o_Stuff_Error = stuff_err_q;
   assign bus.o_Bus_Idle    = bus_idle_q;

endmodule

// File: tb/tb_can_bit_destuffer.sv
// Bench for can_bit_destuffer: directed bit sequences, expected strobes (value + cycle) queued by the
// stimulus and checked by an independent monitor; status flags are checked at bit boundaries.
module tb_can_bit_destuffer;
   localparam int CPB = 10;
   localparam int SP  = 7;
   localparam int IB  = 11;

   typedef struct {
      logic data;
      int   cyc;
   } exp_t;

   logic i_Clock = 1'b0;
   logic i_Reset;
   int   cyc = 0;
   int   compared = 0;
   int   mismatched = 0;
   exp_t sb_q[$];

   can_bit_destuffer_if bus ();

   can_bit_destuffer #(
      .CLKS_PER_BIT(CPB),
      .SAMPLE_POINT(SP),
      .IDLE_BITS   (IB)
   ) dut (
      .i_Clock(i_Clock),
      .i_Reset(i_Reset),
      .bus    (bus)
   );

   always #5 i_Clock = ~i_Clock;

   always @(posedge i_Clock) cyc <= cyc + 1;

   always @(negedge i_Clock) begin
      if (bus.o_Data_Valid === 1'b1) begin
         compared++;
         if (sb_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_strobe: data %0b at cycle %0d, required no strobe", bus.o_Data, cyc);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            if (bus.o_Data !== e.data || cyc != e.cyc) begin
               mismatched++;
               $display("FAIL strobe: data %0b at cycle %0d, required data %0b at cycle %0d",
                        bus.o_Data, cyc, e.data, e.cyc);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // One nominal bit time; with hard sync two clocks after the edge, the strobe lands 10 cycles on.
   task automatic send_bit(input logic b, input logic en, input logic strobe);
      exp_t e;
      bus.i_Rx = b;
      bus.i_Stuff_Enable = en;
      if (strobe) begin
         e.data = b;
         e.cyc  = cyc + CPB;
         sb_q.push_back(e);
      end
      repeat (CPB) begin
         @(posedge i_Clock);
         #1;
      end
   endtask

   task automatic send_n(input int n, input logic b, input logic en, input logic strobe);
      for (int i = 0; i < n; i++) send_bit(b, en, strobe);
   endtask

   initial begin
      i_Reset = 1'b1;
      bus.i_Rx = 1'b1;
      bus.i_Stuff_Enable = 1'b0;
      #2;
      check("reset_data", bus.o_Data, 1);
      check("reset_valid", bus.o_Data_Valid, 0);
      check("reset_stuff_err", bus.o_Stuff_Error, 0);
      check("reset_bus_idle", bus.o_Bus_Idle, 0);
      repeat (3) begin @(posedge i_Clock); #1; end
      i_Reset = 1'b0;

      // Idle detection: 11th sample lands 108 clocks after release.
      repeat (107) begin @(posedge i_Clock); #1; end
      check("idle_before_11th", bus.o_Bus_Idle, 0);
      @(posedge i_Clock); #1;
      check("idle_after_11th", bus.o_Bus_Idle, 1);
      check("idle_data_hold", bus.o_Data, 1);

      // Plain frame 0,1,1,0,1 then recessive run back to idle.
      send_bit(0, 1, 1);
      check("frame_idle_drop", bus.o_Bus_Idle, 0);
      send_bit(1, 1, 1);
      send_bit(1, 1, 1);
      send_bit(0, 1, 1);
      send_bit(1, 1, 1);
      send_n(9, 1, 0, 1);
      check("frame_idle_not_yet", bus.o_Bus_Idle, 0);
      send_bit(1, 0, 1);
      check("frame_idle_back", bus.o_Bus_Idle, 1);

      // Stuff bit after five dominant bits is dropped.
      send_n(5, 0, 1, 1);
      send_bit(1, 1, 0);
      send_bit(0, 1, 1);
      check("stuff_no_error", bus.o_Stuff_Error, 0);
      send_n(11, 1, 0, 1);
      check("stuff_idle_back", bus.o_Bus_Idle, 1);

      // Six equal bits: stuff error, then SOF ignored until the bus idles again.
      send_n(5, 0, 1, 1);
      send_bit(0, 1, 0);
      check("err_flag", bus.o_Stuff_Error, 1);
      check("err_bus_idle", bus.o_Bus_Idle, 0);
      send_n(2, 1, 0, 0);
      send_bit(0, 0, 0);
      send_n(10, 1, 0, 0);
      check("err_idle_not_yet", bus.o_Bus_Idle, 0);
      send_bit(1, 0, 0);
      check("err_idle_back", bus.o_Bus_Idle, 1);
      check("err_sticky", bus.o_Stuff_Error, 1);
      send_bit(0, 1, 1);
      check("err_cleared_by_sof", bus.o_Stuff_Error, 0);
      send_bit(1, 1, 1);
      send_n(10, 1, 0, 1);
      check("err_frame_idle", bus.o_Bus_Idle, 1);

      // Destuffing off: long recessive run is delivered without error.
      send_bit(0, 0, 1);
      send_n(10, 1, 0, 1);
      check("nostuff_no_error", bus.o_Stuff_Error, 0);
      check("nostuff_idle_not_yet", bus.o_Bus_Idle, 0);
      send_bit(1, 0, 1);
      check("nostuff_idle", bus.o_Bus_Idle, 1);

      // Reset pulse during the third bit of a frame.
      send_bit(0, 1, 1);
      send_bit(0, 1, 1);
      bus.i_Rx = 1'b1;
      repeat (4) begin @(posedge i_Clock); #1; end
      i_Reset = 1'b1;
      #1;
      check("midreset_data", bus.o_Data, 1);
      check("midreset_valid", bus.o_Data_Valid, 0);
      check("midreset_stuff_err", bus.o_Stuff_Error, 0);
      check("midreset_bus_idle", bus.o_Bus_Idle, 0);
      @(posedge i_Clock); #1;
      i_Reset = 1'b0;
      send_n(3, 1, 1, 0);
      send_n(2, 0, 1, 0);
      send_n(2, 1, 1, 0);
      check("midreset_no_idle", bus.o_Bus_Idle, 0);
      check("pending_strobes", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
